// File: rtl/alu_pkg.sv
// ------------------------------------------------------------------
// alu_pkg: shared opcode, decode-class and FSM definitions
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  localparam int OPC_WIDTH = 4;

  localparam logic [OPC_WIDTH-1:0] OPC_AND     = 4'b0000;
  localparam logic [OPC_WIDTH-1:0] OPC_OR      = 4'b0001;
  localparam logic [OPC_WIDTH-1:0] OPC_ADD     = 4'b0010;
  localparam logic [OPC_WIDTH-1:0] OPC_SLL     = 4'b0011;
  localparam logic [OPC_WIDTH-1:0] OPC_XOR     = 4'b0100;
  localparam logic [OPC_WIDTH-1:0] OPC_SRL     = 4'b0101;
  localparam logic [OPC_WIDTH-1:0] OPC_SUB     = 4'b0110;
  localparam logic [OPC_WIDTH-1:0] OPC_SRA     = 4'b0111;
  localparam logic [OPC_WIDTH-1:0] OPC_SLT     = 4'b1000;
  localparam logic [OPC_WIDTH-1:0] OPC_SLTU    = 4'b1001;
  localparam logic [OPC_WIDTH-1:0] OPC_ILLEGAL = 4'b1111;

  localparam logic [1:0] ALUOP_LS  = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_RSV = 2'b11;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_MUL  = 3'd2,
    ST_DIV  = 3'd3,
    ST_FIX  = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/mdu_iter.sv
// ------------------------------------------------------------------
// mdu_iter: radix-2 shift-add multiply / restoring divide datapath
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module mdu_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic            is_div,
  input  logic [XLEN-1:0] mag_a,
  input  logic [XLEN-1:0] mag_b,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            last
);

  localparam int CNT_W = $clog2(XLEN + 1);

  logic [XLEN-1:0]  acc_q, acc_d;
  logic [XLEN-1:0]  lo_q, lo_d;
  logic [XLEN-1:0]  opd_q, opd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [XLEN:0]    sum;
  logic [XLEN:0]    shifted;
  logic [XLEN-1:0]  diff;
  logic             ge;

  // Multiply: acc:lo is the product, lo starts as the multiplier.
  // Divide:   acc is the partial remainder, lo shifts dividend out / quotient in.
  always_comb begin
    acc_d   = acc_q;
    lo_d    = lo_q;
    opd_d   = opd_q;
    cnt_d   = cnt_q;
    sum     = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
    shifted = {acc_q, lo_q[XLEN-1]};
    ge      = (shifted >= {1'b0, opd_q});
    diff    = shifted[XLEN-1:0] - opd_q;
    if (load) begin
      acc_d = '0;
      lo_d  = mag_a;
      opd_d = mag_b;
      cnt_d = '0;
    end else if (step) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (is_div) begin
        acc_d = ge ? diff : shifted[XLEN-1:0];
        lo_d  = {lo_q[XLEN-2:0], ge};
      end else begin
        acc_d = sum[XLEN:1];
        lo_d  = {sum[0], lo_q[XLEN-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      lo_q  <= '0;
      opd_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      lo_q  <= lo_d;
      opd_q <= opd_d;
      cnt_q <= cnt_d;
    end
  end

  assign hi   = acc_q;
  assign lo   = lo_q;
  assign last = (cnt_q == CNT_W'(XLEN - 1));

endmodule

`default_nettype wire

// File: rtl/alu_mdu_control.sv
// ------------------------------------------------------------------
// alu_mdu_control: ALU control decode with iterative M-extension unit
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module alu_mdu_control #(
  parameter int XLEN  = 32,
  parameter int OPC_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       ALUOp,
  input  logic [6:0]       func7,
  input  logic [2:0]       func3,
  input  logic [XLEN-1:0]  op_a,
  input  logic [XLEN-1:0]  op_b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OPC_W-1:0] alu_opcode,
  output logic             out_is_mdu,
  output logic             out_illegal,
  output logic [XLEN-1:0]  result
);

  import alu_pkg::*;

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [OPC_W-1:0] alu_opcode_q, alu_opcode_d;
  logic             out_is_mdu_q, out_is_mdu_d;
  logic             out_illegal_q, out_illegal_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [XLEN-1:0]  a_q, a_d;
  logic [XLEN-1:0]  b_q, b_d;
  logic [2:0]       func3_q, func3_d;
  logic             neg_q, neg_d;
  logic             div0_q, div0_d;

  logic                 accept;
  logic [OPC_WIDTH-1:0] dec_opc;
  logic                 dec_mdu;
  logic                 dec_ill;
  logic                 abs_a, abs_b, prep_neg;
  logic [XLEN-1:0]      mag_a, mag_b;
  logic [XLEN-1:0]      mdu_hi, mdu_lo;
  logic                 mdu_last;
  logic [XLEN-1:0]      fixed_res;

  assign in_ready = (state_q == ST_IDLE) && !out_valid_q && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    dec_opc = OPC_ILLEGAL;
    dec_mdu = 1'b0;
    dec_ill = 1'b1;
    case (ALUOp)
      ALUOP_LS: begin dec_opc = OPC_ADD; dec_ill = 1'b0; end
      ALUOP_BR: begin dec_opc = OPC_SUB; dec_ill = 1'b0; end
      ALUOP_R: begin
        if (func7 == F7_BASE || func7 == F7_ALT) begin
          dec_ill = 1'b0;
          case (func3)
            3'b000:  dec_opc = func7[5] ? OPC_SUB : OPC_ADD;
            3'b001:  dec_opc = OPC_SLL;
            3'b010:  dec_opc = OPC_SLT;
            3'b011:  dec_opc = OPC_SLTU;
            3'b100:  dec_opc = OPC_XOR;
            3'b101:  dec_opc = func7[5] ? OPC_SRA : OPC_SRL;
            3'b110:  dec_opc = OPC_OR;
            default: dec_opc = OPC_AND;
          endcase
        end else if (func7 == F7_MULDIV) begin
          dec_mdu = 1'b1;
          dec_ill = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Magnitudes fed to the unsigned datapath, plus the sign the result must carry.
  always_comb begin
    abs_a    = 1'b0;
    abs_b    = 1'b0;
    prep_neg = 1'b0;
    case (func3_q)
      F3_MULH, F3_DIV: begin
        abs_a    = 1'b1;
        abs_b    = 1'b1;
        prep_neg = a_q[XLEN-1] ^ b_q[XLEN-1];
      end
      F3_MULHSU: begin
        abs_a    = 1'b1;
        prep_neg = a_q[XLEN-1];
      end
      F3_REM: begin
        abs_a    = 1'b1;
        abs_b    = 1'b1;
        prep_neg = a_q[XLEN-1];
      end
      default: ;
    endcase
    mag_a = (abs_a && a_q[XLEN-1]) ? -a_q : a_q;
    mag_b = (abs_b && b_q[XLEN-1]) ? -b_q : b_q;
  end

  // High half of the negated 2*XLEN product is ~hi plus the carry out of -lo.
  always_comb begin
    case (func3_q)
      F3_MUL:            fixed_res = mdu_lo;
      F3_MULH, F3_MULHSU: fixed_res = neg_q ? (~mdu_hi + XLEN'(mdu_lo == '0)) : mdu_hi;
      F3_MULHU:          fixed_res = mdu_hi;
      F3_DIV:            fixed_res = div0_q ? '1 : (neg_q ? -mdu_lo : mdu_lo);
      F3_DIVU:           fixed_res = mdu_lo;
      F3_REM:            fixed_res = neg_q ? -mdu_hi : mdu_hi;
      default:           fixed_res = mdu_hi;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    out_valid_d   = out_valid_q;
    alu_opcode_d  = alu_opcode_q;
    out_is_mdu_d  = out_is_mdu_q;
    out_illegal_d = out_illegal_q;
    result_d      = result_q;
    a_d           = a_q;
    b_d           = b_q;
    func3_d       = func3_q;
    neg_d         = neg_q;
    div0_d        = div0_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          alu_opcode_d  = OPC_W'(dec_opc);
          out_is_mdu_d  = dec_mdu;
          out_illegal_d = dec_ill;
          a_d           = op_a;
          b_d           = op_b;
          func3_d       = func3;
          if (dec_mdu) begin
            state_d = ST_PREP;
          end else begin
            out_valid_d = 1'b1;
            result_d    = '0;
          end
        end
      end
      ST_PREP: begin
        neg_d   = prep_neg;
        div0_d  = (b_q == '0);
        state_d = func3_q[2] ? ST_DIV : ST_MUL;
      end
      ST_MUL, ST_DIV: begin
        if (mdu_last) state_d = ST_FIX;
      end
      ST_FIX: begin
        result_d    = fixed_res;
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      out_valid_q   <= 1'b0;
      alu_opcode_q  <= '0;
      out_is_mdu_q  <= 1'b0;
      out_illegal_q <= 1'b0;
      result_q      <= '0;
      a_q           <= '0;
      b_q           <= '0;
      func3_q       <= '0;
      neg_q         <= 1'b0;
      div0_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      out_valid_q   <= out_valid_d;
      alu_opcode_q  <= alu_opcode_d;
      out_is_mdu_q  <= out_is_mdu_d;
      out_illegal_q <= out_illegal_d;
      result_q      <= result_d;
      a_q           <= a_d;
      b_q           <= b_d;
      func3_q       <= func3_d;
      neg_q         <= neg_d;
      div0_q        <= div0_d;
    end
  end

  mdu_iter #(
    .XLEN (XLEN)
  ) u_mdu_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (state_q == ST_PREP),
    .step   ((state_q == ST_MUL) || (state_q == ST_DIV)),
    .is_div (state_q == ST_DIV),
    .mag_a  (mag_a),
    .mag_b  (mag_b),
    .hi     (mdu_hi),
    .lo     (mdu_lo),
    .last   (mdu_last)
  );

  assign out_valid   = out_valid_q;
  assign alu_opcode  = alu_opcode_q;
  assign out_is_mdu  = out_is_mdu_q;
  assign out_illegal = out_illegal_q;
  assign result      = result_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_mdu_control.sv
// ------------------------------------------------------------------
// tb_alu_mdu_control: directed self-checking bench for alu_mdu_control
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_alu_mdu_control;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  ALUOp;
  logic [6:0]  func7;
  logic [2:0]  func3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_opcode;
  logic        out_is_mdu;
  logic        out_illegal;
  logic [31:0] result;

  int n_tests;
  int n_fail;

  alu_mdu_control #(
    .XLEN  (32),
    .OPC_W (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .ALUOp       (ALUOp),
    .func7       (func7),
    .func3       (func3),
    .op_a        (op_a),
    .op_b        (op_b),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_opcode  (alu_opcode),
    .out_is_mdu  (out_is_mdu),
    .out_illegal (out_illegal),
    .result      (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One request end to end; hold>0 keeps out_ready low for that many cycles after out_valid.
  task automatic do_op(input string tag, input logic [1:0] aop, input logic [6:0] f7,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input logic [3:0] exp_opc,
                       input logic exp_mdu, input logic exp_ill, input int exp_lat,
                       input int hold);
    int          cyc;
    bit          busy_ok;
    bit          stable;
    logic [31:0] r0;
    @(negedge clk);
    ALUOp     = aop;
    func7     = f7;
    func3     = f3;
    op_a      = a;
    op_b      = b;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    check({tag, ":in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    ALUOp    = 2'($urandom);
    func7    = 7'($urandom);
    func3    = 3'($urandom);
    op_a     = $urandom;
    op_b     = $urandom;
    cyc      = 1;
    busy_ok  = 1'b1;
    while (!out_valid && cyc < 100) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, ":latency"}, cyc, exp_lat);
    check({tag, ":result"}, result, exp_res);
    check({tag, ":opcode"}, alu_opcode, exp_opc);
    check({tag, ":is_mdu"}, out_is_mdu, exp_mdu);
    check({tag, ":illegal"}, out_illegal, exp_ill);
    if (exp_mdu) check({tag, ":busy"}, busy_ok, 1);
    if (hold > 0) begin
      stable = 1'b1;
      r0     = result;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        if (!out_valid || result !== r0 || in_ready) stable = 1'b0;
      end
      check({tag, ":hold_stable"}, stable, 1);
      @(negedge clk);
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check({tag, ":valid_clear"}, out_valid, 0);
    check({tag, ":ready_after"}, in_ready, 1);
  endtask

  // Starts a MUL and lets it run until iteration 10 is in progress.
  task automatic start_mul(input string tag);
    @(negedge clk);
    ALUOp     = 2'b10;
    func7     = 7'b0000001;
    func3     = 3'b000;
    op_a      = 32'd3;
    op_b      = 32'd5;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    check({tag, ":in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
  endtask

  task automatic expect_quiet(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check({tag, ":no_output"}, seen, 0);
    check({tag, ":idle_ready"}, in_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    clk       = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b0;
    ALUOp     = 2'b00;
    func7     = 7'b0;
    func3     = 3'b0;
    op_a      = 32'b0;
    op_b      = 32'b0;

    repeat (3) @(posedge clk); #1;
    check("rst:out_valid", out_valid, 0);
    check("rst:opcode", alu_opcode, 4'b0000);
    check("rst:is_mdu", out_is_mdu, 0);
    check("rst:illegal", out_illegal, 0);
    check("rst:result", result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst:in_ready", in_ready, 1);

    // Base decode
    do_op("sub",    2'b10, 7'b0100000, 3'b000, 0, 0, 0, 4'b0110, 0, 0, 1, 0);
    do_op("rsv",    2'b11, 7'b0000000, 3'b000, 0, 0, 0, 4'b1111, 0, 1, 1, 0);
    do_op("ldst",   2'b00, 7'b1111111, 3'b111, 0, 0, 0, 4'b0010, 0, 0, 1, 0);
    do_op("branch", 2'b01, 7'b0000000, 3'b010, 0, 0, 0, 4'b0110, 0, 0, 1, 0);
    do_op("add",    2'b10, 7'b0000000, 3'b000, 0, 0, 0, 4'b0010, 0, 0, 1, 0);
    do_op("sll",    2'b10, 7'b0000000, 3'b001, 0, 0, 0, 4'b0011, 0, 0, 1, 0);
    do_op("slt",    2'b10, 7'b0000000, 3'b010, 0, 0, 0, 4'b1000, 0, 0, 1, 0);
    do_op("sltu",   2'b10, 7'b0000000, 3'b011, 0, 0, 0, 4'b1001, 0, 0, 1, 0);
    do_op("xor",    2'b10, 7'b0000000, 3'b100, 0, 0, 0, 4'b0100, 0, 0, 1, 0);
    do_op("srl",    2'b10, 7'b0000000, 3'b101, 0, 0, 0, 4'b0101, 0, 0, 1, 0);
    do_op("sra",    2'b10, 7'b0100000, 3'b101, 0, 0, 0, 4'b0111, 0, 0, 1, 0);
    do_op("or",     2'b10, 7'b0000000, 3'b110, 0, 0, 0, 4'b0001, 0, 0, 1, 0);
    do_op("and",    2'b10, 7'b0000000, 3'b111, 0, 0, 0, 4'b0000, 0, 0, 1, 0);
    do_op("bad_f7", 2'b10, 7'b0000010, 3'b000, 0, 0, 0, 4'b1111, 0, 1, 1, 0);

    // Multiply
    do_op("mul",    2'b10, 7'b0000001, 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 4'b1111, 1, 0, 35, 0);
    do_op("mulhu",  2'b10, 7'b0000001, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b1111, 1, 0, 35, 0);
    do_op("mulh",   2'b10, 7'b0000001, 3'b001, 32'h80000000, 32'd2, 32'hFFFFFFFF, 4'b1111, 1, 0, 35, 0);
    do_op("mulh_pp",2'b10, 7'b0000001, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b1111, 1, 0, 35, 0);
    do_op("mulhsu", 2'b10, 7'b0000001, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1111, 1, 0, 35, 0);

    // Divide / remainder, overflow and divide-by-zero corners
    do_op("div_ovf",2'b10, 7'b0000001, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 4'b1111, 1, 0, 35, 0);
    do_op("rem_ovf",2'b10, 7'b0000001, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 4'b1111, 1, 0, 35, 0);
    do_op("rem_neg",2'b10, 7'b0000001, 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 4'b1111, 1, 0, 35, 0);
    do_op("div_neg",2'b10, 7'b0000001, 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 4'b1111, 1, 0, 35, 0);
    do_op("divu_0", 2'b10, 7'b0000001, 3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 4'b1111, 1, 0, 35, 0);
    do_op("remu_0", 2'b10, 7'b0000001, 3'b111, 32'd5, 32'd0, 32'd5, 4'b1111, 1, 0, 35, 0);
    do_op("div_0",  2'b10, 7'b0000001, 3'b100, 32'd5, 32'd0, 32'hFFFFFFFF, 4'b1111, 1, 0, 35, 0);
    do_op("rem_0",  2'b10, 7'b0000001, 3'b110, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 4'b1111, 1, 0, 35, 0);
    do_op("divu",   2'b10, 7'b0000001, 3'b101, 32'd100, 32'd7, 32'd14, 4'b1111, 1, 0, 35, 0);
    do_op("remu",   2'b10, 7'b0000001, 3'b111, 32'd100, 32'd7, 32'd2, 4'b1111, 1, 0, 35, 0);

    // Back-pressure on a completed DIV
    do_op("div_bp", 2'b10, 7'b0000001, 3'b100, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 4'b1111, 1, 0, 35, 10);

    // Flush mid-multiply, with a competing request in the flush cycle
    start_mul("flush");
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    ALUOp    = 2'b00;
    check("flush:in_ready_low", in_ready, 0);
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    expect_quiet("flush");
    do_op("flush_add", 2'b00, 7'b0, 3'b0, 0, 0, 0, 4'b0010, 0, 0, 1, 0);

    // Asynchronous reset mid-multiply
    start_mul("areset");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("areset:valid_low", out_valid, 0);
    check("areset:result", result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("areset:ready_first_edge", in_ready, 1);
    expect_quiet("areset");
    do_op("areset_add", 2'b00, 7'b0, 3'b0, 0, 0, 0, 4'b0010, 0, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_mdu_control.md
ALU_MDU_CONTROL -- requirements
Module: alu_mdu_control

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (legal: 8..64, even).
REQ-002 SHALL have parameter OPC_W, default 4, alu_opcode width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  in  1  request present.
REQ-006 in_ready  out  1  block accepts a request this cycle.
REQ-007 ALUOp  in  2  main-decoder class (00 load/store, 01 branch, 10 R-type, 11 reserved).
REQ-008 func7  in  7; func3  in  3  instruction fields.
REQ-009 op_a, op_b  in  XLEN  rs1/rs2 values, used only for M-extension ops.
REQ-010 flush  in  1  synchronous abort of any in-flight operation.
REQ-011 out_valid  out  1; out_ready  in  1  output handshake.
REQ-012 alu_opcode  out  OPC_W; out_is_mdu  out  1; out_illegal  out  1; result  out  XLEN.

Function
REQ-013 Transfers occur when valid&ready are both high at a clock edge; otherwise there is no transfer.
REQ-014 in_ready SHALL equal (state==IDLE) && !out_valid && !flush.
REQ-015 Base decode SHALL be: ALUOp 00->0010 ADD; 01->0110 SUB; 10 with func7 0000000/0100000: func3 000->0010 ADD or 0110 SUB (func7[5]), 001->0011 SLL, 010->1000 SLT, 011->1001 SLTU, 100->0100 XOR, 101->0101 SRL or 0111 SRA (func7[5]), 110->0001 OR, 111->0000 AND.
REQ-016 ALUOp 11, or ALUOp 10 with any other func7 except 0000001, SHALL output alu_opcode 1111 and out_illegal=1.
REQ-017 A base or illegal request SHALL produce out_valid exactly one cycle after acceptance, with out_is_mdu=0 and result=0.
REQ-018 ALUOp 10 with func7 0000001 SHALL be an MDU op: func3 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU; alu_opcode=1111, out_is_mdu=1, out_illegal=0.
REQ-019 FSM states SHALL be IDLE, PREP, MUL, DIV, FIX; transitions: IDLE->PREP on an accepted MDU op; PREP->MUL|DIV; MUL/DIV run exactly XLEN iterations, then ->FIX; FIX->IDLE with out_valid set.
REQ-020 MDU latency SHALL be exactly XLEN+3 cycles from the acceptance edge to out_valid high (PREP 1, iterate XLEN, FIX 1, register 1).
REQ-021 PREP SHALL take absolute values of the signed operands per op (MULH: both; MULHSU: op_a only; DIV/REM: both) and record the result sign.
REQ-022 MUL SHALL be radix-2 shift-add on a 2*XLEN product; MUL returns low XLEN bits, MULH/MULHSU/MULHU return high XLEN bits after sign fix.
REQ-023 DIV SHALL be restoring division; the quotient sign is sign(a)^sign(b), and the remainder takes the sign of the dividend.
REQ-024 Divide by zero SHALL return quotient all-ones (DIV and DIVU) and remainder = op_a, taking the normal latency.
REQ-025 Signed overflow (op_a = most-negative, op_b = -1) SHALL return quotient = op_a and remainder = 0.
REQ-026 out_valid and all outputs SHALL hold stable until out_ready; out_valid clears on the transfer edge.
REQ-027 flush SHALL force state IDLE and out_valid=0 at the next edge, discarding any pending output; a request with in_valid in the same cycle is not accepted.
REQ-028 Operands SHALL be captured at acceptance; later changes to op_a/op_b/func fields have no effect.

Reset
REQ-029 While rst_n=0: state=IDLE, out_valid=0, alu_opcode=0000, out_is_mdu=0, out_illegal=0, result=0, iteration counter=0, datapath registers=0.
REQ-030 Assertion mid-operation SHALL abort immediately with no output; in_ready=1 on the first edge after deassertion.

Structure
REQ-031 Shared package alu_pkg SHALL hold the OPC_W opcode constants (ADD..SLTU, ILLEGAL=1111), the ALUOp class constants, the M-extension func7 constant and the FSM state enum.
REQ-032 The iterative datapath SHALL be one sub-module, mdu_iter (operands, counter, shift-add/restore step); the decode and handshake logic stays in the top.

Verification (XLEN=32)
REQ-033 ALUOp=10, func7=0100000, func3=000, out_ready=1 -> next cycle out_valid=1, alu_opcode=0110, out_is_mdu=0; ALUOp=11 -> 1111, out_illegal=1.
REQ-034 MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB exactly 35 cycles after acceptance; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-035 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0; REM -7/2 -> 0xFFFFFFFF.
REQ-036 DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; in_ready low throughout.
REQ-037 out_ready=0 for 10 cycles after DIV completes -> outputs stable, in_ready=0; out_ready=1 -> one transfer, then in_ready=1.
REQ-038 flush, or rst_n low, at iteration 10 of a MUL -> out_valid never rises; the following ADD request completes normally.
